// File: rtl/pipelined_addsub_pkg.sv
// Shared types and helpers for the segmented add/subtract pipeline.
// PIPELINED_ADDSUB_SATURATE_EN adds the per-operation sat flag to the stage payload.
package pipelined_addsub_pkg;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Saturation target is {sign, fill...}: max positive when A >= 0, min negative otherwise.
  function automatic logic sat_sign_bit(input logic a_msb);
    return a_msb;
  endfunction

  function automatic logic sat_fill_bit(input logic a_msb);
    return ~a_msb;
  endfunction

  // Control half of an intermediate stage payload; the width-dependent
  // operand remainders and partial sum live beside it in the pipeline.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    logic sat;
`endif
  } seg_ctrl_t;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result bus for pipelined_addsub: valid/ready on both sides.
// PIPELINED_ADDSUB_SATURATE_EN adds the sat input.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
`ifdef PIPELINED_ADDSUB_SATURATE_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             overflow;

  modport master (
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    output sat,
`endif
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, overflow
  );

  modport slave (
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    input  sat,
`endif
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, Sum, Cout, overflow
  );
endinterface

// File: rtl/pipelined_addsub_segment.sv
// One combinational slice of the carry chain; subtract inverts b locally,
// the caller supplies the already-adjusted carry in.
module addsub_segment
  import pipelined_addsub_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          sub,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout
);
  logic [SW-1:0] b_eff;

  assign b_eff     = sub ? ~b : b;
  assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{SW{1'b0}}, cin};
endmodule

// File: rtl/pipelined_addsub.sv
// Add/subtract unit with the carry chain split into STAGES registered segments.
// Define PIPELINED_ADDSUB_SATURATE_EN to enable the per-operation saturating clamp.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pipelined_addsub_if.slave   bus
);
  localparam int SW = seg_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic [STAGES-1:0] stage_valid;
  logic [STAGES:0]   stage_ready;

  // A stage may load when it is empty or its content is leaving this cycle.
  always_comb begin
    stage_ready         = '0;
    stage_ready[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = !stage_valid[k] || stage_ready[k+1];
    end
  end

  assign bus.in_ready = stage_ready[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic          up_valid;
    logic [SW-1:0] a_seg;
    logic [SW-1:0] b_seg;
    logic [SW-1:0] s_seg;
    logic          cin_seg;
    logic          sub_seg;
    logic          cout_seg;
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    logic          sat_seg;
`endif

    if (gi == 0) begin : g_from_bus
      assign up_valid = bus.in_valid;
      assign a_seg    = bus.A[SW-1:0];
      assign b_seg    = bus.B[SW-1:0];
      assign sub_seg  = bus.sub;
      // Subtract turns borrow-in into carry-in of A + ~B.
      assign cin_seg  = bus.Cin ^ bus.sub;
`ifdef PIPELINED_ADDSUB_SATURATE_EN
      assign sat_seg  = bus.sat;
`endif
    end else begin : g_from_reg
      assign up_valid = g_stage[gi-1].g_mid.ctrl_reg.valid;
      assign a_seg    = g_stage[gi-1].g_mid.a_rem_reg[SW-1:0];
      assign b_seg    = g_stage[gi-1].g_mid.b_rem_reg[SW-1:0];
      assign sub_seg  = g_stage[gi-1].g_mid.ctrl_reg.sub;
      assign cin_seg  = g_stage[gi-1].g_mid.ctrl_reg.carry;
`ifdef PIPELINED_ADDSUB_SATURATE_EN
      assign sat_seg  = g_stage[gi-1].g_mid.ctrl_reg.sat;
`endif
    end

    addsub_segment #(.SW(SW)) u_seg (
      .a    (a_seg),
      .b    (b_seg),
      .sub  (sub_seg),
      .cin  (cin_seg),
      .s    (s_seg),
      .cout (cout_seg)
    );

    if (gi < STAGES - 1) begin : g_mid
      localparam int REM = WIDTH - (gi + 1) * SW;
      localparam int DONE = (gi + 1) * SW;

      seg_ctrl_t       ctrl_reg;
      logic [DONE-1:0] sum_reg;
      logic [DONE-1:0] sum_next;
      logic [REM-1:0]  a_rem_reg;
      logic [REM-1:0]  b_rem_reg;
      logic [REM-1:0]  a_rem_next;
      logic [REM-1:0]  b_rem_next;

      if (gi == 0) begin : g_first
        assign a_rem_next = bus.A[WIDTH-1:SW];
        assign b_rem_next = bus.B[WIDTH-1:SW];
        assign sum_next   = s_seg;
      end else begin : g_next
        assign a_rem_next = g_stage[gi-1].g_mid.a_rem_reg[REM+SW-1:SW];
        assign b_rem_next = g_stage[gi-1].g_mid.b_rem_reg[REM+SW-1:SW];
        assign sum_next   = {s_seg, g_stage[gi-1].g_mid.sum_reg};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctrl_reg  <= '0;
          sum_reg   <= '0;
          a_rem_reg <= '0;
          b_rem_reg <= '0;
        end else if (stage_ready[gi]) begin
          ctrl_reg.valid <= up_valid;
          if (up_valid) begin
            ctrl_reg.carry <= cout_seg;
            ctrl_reg.sub   <= sub_seg;
`ifdef PIPELINED_ADDSUB_SATURATE_EN
            ctrl_reg.sat   <= sat_seg;
`endif
            sum_reg        <= sum_next;
            a_rem_reg      <= a_rem_next;
            b_rem_reg      <= b_rem_next;
          end
        end
      end

      assign stage_valid[gi] = ctrl_reg.valid;
    end else begin : g_last
      logic [WIDTH-1:0] sum_raw;
      logic [WIDTH-1:0] sum_final;
      logic [WIDTH-1:0] sum_reg;
      logic             a_msb;
      logic             ovf;
      logic             valid_reg;
      logic             cout_reg;
      logic             ovf_reg;

      if (gi == 0) begin : g_single
        assign sum_raw = s_seg;
      end else begin : g_join
        assign sum_raw = {s_seg, g_stage[gi-1].g_mid.sum_reg};
      end

      // The top segment always owns the MSBs, so the sign checks are local.
      assign a_msb = a_seg[SW-1];
      assign ovf   = (a_msb == (b_seg[SW-1] ^ sub_seg)) && (sum_raw[WIDTH-1] != a_msb);

`ifdef PIPELINED_ADDSUB_SATURATE_EN
      assign sum_final = (sat_seg && ovf)
                       ? {sat_sign_bit(a_msb), {(WIDTH-1){sat_fill_bit(a_msb)}}}
                       : sum_raw;
`else
      assign sum_final = sum_raw;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          sum_reg   <= '0;
          cout_reg  <= 1'b0;
          ovf_reg   <= 1'b0;
        end else if (stage_ready[gi]) begin
          valid_reg <= up_valid;
          if (up_valid) begin
            sum_reg  <= sum_final;
            cout_reg <= cout_seg;
            ovf_reg  <= ovf;
          end
        end
      end

      assign stage_valid[gi] = valid_reg;
      assign bus.out_valid   = valid_reg;
      assign bus.Sum         = sum_reg;
      assign bus.Cout        = cout_reg;
      assign bus.overflow    = ovf_reg;
    end
  end
endmodule
